mem_sequencer: RTL and testbench

Memory-access sequencer between the SLC-3 control unit and the external 16-bit asynchronous SRAM. Turns the control unit's level requests (`Mem_OE` read, `Mem_WE` write) into correctly timed SRAM strobes with a parameterised number of wait states, and returns a `Mem_Ready` completion pulse. The control unit no longer relies on a fixed count of memory states. Also decodes the memory-mapped switch and hex-display I/O word at `0xFFFF`.

---
 rtl/mem_sequencer.sv | 124 ++++++++++++
 tb/tb_mem_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// SLC-3 memory sequencer: turns Mem_OE/Mem_WE level requests into timed SRAM strobes with WAIT_STATES wait states.
// Define MEM_IO_MAP_EN to route IO_ADDR accesses to SW (read) and HEX_out (write).
module mem_sequencer #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] SW,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic [15:0] HEX_out
);

  // state    | meaning
  // IDLE     | waiting for a request
  // RD       | CE/OE low for WAIT_STATES+1 cycles
  // RD_CAP   | strobes still low, SRAM data captured
  // WR_SETUP | CE low, data driven, WE high
  // WR_PULSE | WE low for WAIT_STATES+1 cycles
  // WR_HOLD  | WE high, CE and data still driven
  // IO       | switch / hex register access
  // DONE     | Mem_Ready on first cycle, wait for request to drop
  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, IO, DONE
  } state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       is_write;
  logic       accept;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_WE || Mem_OE) begin
          accept    = 1'b1;
          state_nxt = Mem_WE ? WR_SETUP : RD;
`ifdef MEM_IO_MAP_EN
          if (MAR == IO_ADDR) state_nxt = IO;
`endif
        end
      end
      RD:       if (wait_cnt == 3'd0) state_nxt = RD_CAP;
      RD_CAP:   state_nxt = DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (wait_cnt == 3'd0) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = DONE;
`ifdef MEM_IO_MAP_EN
      IO:       state_nxt = DONE;
`endif
      DONE:     if (!Mem_OE && !Mem_WE) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt    <= WS;
      is_write    <= 1'b0;
      SRAM_ADDR   <= 16'h0000;
      SRAM_DQ_out <= 16'h0000;
      Data_to_CPU <= 16'h0000;
      Mem_Ready   <= 1'b0;
      SRAM_CE_n   <= 1'b1;
      SRAM_OE_n   <= 1'b1;
      SRAM_WE_n   <= 1'b1;
      SRAM_DQ_oe  <= 1'b0;
    end else begin
      if (state == RD || state == WR_PULSE) begin
        if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
      end else begin
        wait_cnt <= WS;
      end
      if (accept) begin
        is_write  <= Mem_WE;
        SRAM_ADDR <= MAR;
        if (Mem_WE) SRAM_DQ_out <= MDR;
      end
      if (state == RD_CAP) Data_to_CPU <= SRAM_DQ_in;
`ifdef MEM_IO_MAP_EN
      if (state == IO && !is_write) Data_to_CPU <= SW;
`endif
      Mem_Ready  <= (state_nxt == DONE) && (state != DONE);
      SRAM_CE_n  <= !(state_nxt == RD || state_nxt == RD_CAP ||
                      state_nxt == WR_SETUP || state_nxt == WR_PULSE || state_nxt == WR_HOLD);
      SRAM_OE_n  <= !(state_nxt == RD || state_nxt == RD_CAP);
      SRAM_WE_n  <= !(state_nxt == WR_PULSE);
      SRAM_DQ_oe <= (state_nxt == WR_SETUP || state_nxt == WR_PULSE || state_nxt == WR_HOLD);
    end
  end

`ifdef MEM_IO_MAP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                  HEX_out <= 16'h0000;
    else if (state == IO && is_write) HEX_out <= SRAM_DQ_out;
  end
`else
  wire unused_io = ^{SW, IO_ADDR};
  assign HEX_out = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: WAIT_STATES=2 and WAIT_STATES=0 instances, each with a small SRAM model.
module tb_mem_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        oe2 = 1'b0, we2 = 1'b0, oe0 = 1'b0, we0 = 1'b0;
  logic [15:0] MAR = 16'h0, MDR = 16'h0, SW = 16'h0;

  logic [15:0] dqi2, dat2, addr2, dqo2, hex2;
  logic        rdy2, dqoe2, ce2, oen2, wen2;
  logic [15:0] dqi0, dat0, addr0, dqo0, hex0;
  logic        rdy0, dqoe0, ce0, oen0, wen0;

  logic [15:0] mem2 [0:255];
  logic [15:0] mem0 [0:255];

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_sequencer #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(oe2), .Mem_WE(we2), .MAR(MAR), .MDR(MDR), .SW(SW),
    .SRAM_DQ_in(dqi2), .Data_to_CPU(dat2), .Mem_Ready(rdy2), .SRAM_ADDR(addr2),
    .SRAM_DQ_out(dqo2), .SRAM_DQ_oe(dqoe2), .SRAM_CE_n(ce2), .SRAM_OE_n(oen2),
    .SRAM_WE_n(wen2), .HEX_out(hex2));

  mem_sequencer #(.WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(oe0), .Mem_WE(we0), .MAR(MAR), .MDR(MDR), .SW(SW),
    .SRAM_DQ_in(dqi0), .Data_to_CPU(dat0), .Mem_Ready(rdy0), .SRAM_ADDR(addr0),
    .SRAM_DQ_out(dqo0), .SRAM_DQ_oe(dqoe0), .SRAM_CE_n(ce0), .SRAM_OE_n(oen0),
    .SRAM_WE_n(wen0), .HEX_out(hex0));

  // Asynchronous SRAM: combinational read, write recorded while CE/WE are low and data is driven.
  assign dqi2 = (!ce2 && !oen2) ? mem2[addr2[7:0]] : 16'h0000;
  assign dqi0 = (!ce0 && !oen0) ? mem0[addr0[7:0]] : 16'h0000;

  always @(posedge Clk) begin
    if (!ce2 && !wen2 && dqoe2) mem2[addr2[7:0]] <= dqo2;
    if (!ce0 && !wen0 && dqoe0) mem0[addr0[7:0]] <= dqo0;
  end

  int          lat, n_oe, n_we, n_ce, n_dqoe, n_rdy, n_bad, n_ovl;
  logic [15:0] dat_at_rdy, cur_mar, cur_mdr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit d0, input int c);
    logic        rdy, ce, oe, we, dqoe;
    logic [15:0] addr, dq, dat;
    if (d0) begin
      rdy = rdy0; ce = ce0; oe = oen0; we = wen0; dqoe = dqoe0; addr = addr0; dq = dqo0; dat = dat0;
    end else begin
      rdy = rdy2; ce = ce2; oe = oen2; we = wen2; dqoe = dqoe2; addr = addr2; dq = dqo2; dat = dat2;
    end
    if (!ce) begin
      n_ce++;
      if (addr !== cur_mar) n_bad++;
    end
    if (!oe) n_oe++;
    if (!we) n_we++;
    if (dqoe) begin
      n_dqoe++;
      if (dq !== cur_mdr) n_bad++;
    end
    if (dqoe && !oe) n_ovl++;
    if (rdy) begin
      n_rdy++;
      if (lat == 0) begin
        lat = c;
        dat_at_rdy = dat;
      end
    end
  endtask

  // Called at a negedge; request asserted there is sampled by the next rising edge (edge 0).
  task automatic access(input bit d0, input bit oe, input bit we, input logic [15:0] mar,
                        input logic [15:0] mdr, input int hold, input int gap);
    lat = 0; n_oe = 0; n_we = 0; n_ce = 0; n_dqoe = 0; n_rdy = 0; n_bad = 0; n_ovl = 0;
    dat_at_rdy = 16'h0;
    cur_mar = mar; cur_mdr = mdr;
    MAR = mar; MDR = mdr;
    if (d0) begin oe0 = oe; we0 = we; end
    else    begin oe2 = oe; we2 = we; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      sample(d0, c);
      MAR = ~mar;
      MDR = ~mdr;
      if (lat != 0 && c >= lat + hold) break;
    end
    oe0 = 1'b0; we0 = 1'b0; oe2 = 1'b0; we2 = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge Clk);
      sample(d0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem2[i] = 16'h0000;
      mem0[i] = 16'h0000;
    end
    mem2[8'h10] = 16'h1234;
    mem2[8'hFF] = 16'h5A5A;
    mem0[8'h10] = 16'h0BAD;
    mem0[8'h11] = 16'h7777;

    // Reset values
    repeat (2) @(negedge Clk);
    check("rst_ce_n", {31'b0, ce2}, 32'd1);
    check("rst_oe_n", {31'b0, oen2}, 32'd1);
    check("rst_we_n", {31'b0, wen2}, 32'd1);
    check("rst_dq_oe", {31'b0, dqoe2}, 32'd0);
    check("rst_ready", {31'b0, rdy2}, 32'd0);
    check("rst_addr", {16'b0, addr2}, 32'd0);
    check("rst_dq_out", {16'b0, dqo2}, 32'd0);
    check("rst_data", {16'b0, dat2}, 32'd0);
    check("rst_hex", {16'b0, hex2}, 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Read, WAIT_STATES=2
    access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 3);
    check("rd_latency", lat, 32'd5);
    check("rd_oe_cycles", n_oe, 32'd4);
    check("rd_ce_cycles", n_ce, 32'd4);
    check("rd_we_cycles", n_we, 32'd0);
    check("rd_ready_pulses", n_rdy, 32'd1);
    check("rd_data", {16'b0, dat_at_rdy}, 32'h1234);
    check("rd_latched", n_bad, 32'd0);

    // Write, WAIT_STATES=2
    access(1'b0, 1'b0, 1'b1, 16'h0020, 16'hBEEF, 0, 3);
    check("wr_latency", lat, 32'd6);
    check("wr_we_cycles", n_we, 32'd3);
    check("wr_dq_oe_cycles", n_dqoe, 32'd5);
    check("wr_ce_cycles", n_ce, 32'd5);
    check("wr_oe_cycles", n_oe, 32'd0);
    check("wr_ready_pulses", n_rdy, 32'd1);
    check("wr_latched", n_bad, 32'd0);
    check("wr_mem", {16'b0, mem2[8'h20]}, 32'hBEEF);
    check("rd_data_held", {16'b0, dat2}, 32'h1234);

    // Both requests high: write wins
    access(1'b0, 1'b1, 1'b1, 16'h0030, 16'hCAFE, 0, 3);
    check("both_latency", lat, 32'd6);
    check("both_oe_cycles", n_oe, 32'd0);
    check("both_we_cycles", n_we, 32'd3);
    check("both_mem", {16'b0, mem2[8'h30]}, 32'hCAFE);
    check("both_overlap", n_ovl, 32'd0);

    SW = 16'h00A5;
`ifdef MEM_IO_MAP_EN
    access(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 3);
    check("io_rd_latency", lat, 32'd2);
    check("io_rd_data", {16'b0, dat_at_rdy}, 32'h00A5);
    check("io_rd_ce_cycles", n_ce, 32'd0);
    access(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0042, 0, 3);
    check("io_wr_latency", lat, 32'd2);
    check("io_wr_ce_cycles", n_ce, 32'd0);
    check("io_wr_hex", {16'b0, hex2}, 32'h0042);
    check("io_wr_mem_untouched", {16'b0, mem2[8'hFF]}, 32'h5A5A);
`else
    access(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 3);
    check("ffff_rd_latency", lat, 32'd5);
    check("ffff_rd_data", {16'b0, dat_at_rdy}, 32'h5A5A);
    access(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0042, 0, 3);
    check("ffff_wr_latency", lat, 32'd6);
    check("ffff_wr_mem", {16'b0, mem2[8'hFF]}, 32'h0042);
    check("ffff_hex_zero", {16'b0, hex2}, 32'h0000);
`endif

    // WAIT_STATES=0: held request, then re-request one cycle after drop
    access(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 5, 1);
    check("ws0_latency", lat, 32'd3);
    check("ws0_ready_pulses", n_rdy, 32'd1);
    check("ws0_oe_cycles", n_oe, 32'd2);
    check("ws0_data", {16'b0, dat_at_rdy}, 32'h0BAD);
    access(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 0, 3);
    check("b2b_latency", lat, 32'd3);
    check("b2b_data", {16'b0, dat_at_rdy}, 32'h7777);

    // Reset asserted during WR_PULSE
    MAR = 16'h0040; MDR = 16'h1111; we2 = 1'b1;
    repeat (2) @(negedge Clk);
    check("mid_in_pulse", {31'b0, wen2}, 32'd0);
    Reset_n = 1'b0;
    #1;
    check("mid_we_n", {31'b0, wen2}, 32'd1);
    check("mid_ce_n", {31'b0, ce2}, 32'd1);
    check("mid_dq_oe", {31'b0, dqoe2}, 32'd0);
    we2 = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    n_rdy = 0; n_ce = 0;
    cur_mar = 16'h0040; cur_mdr = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (rdy2) n_rdy++;
      if (!ce2) n_ce++;
    end
    check("post_rst_ready", n_rdy, 32'd0);
    check("post_rst_ce", n_ce, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
